mdu_multicycle: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the

---
 rtl/mdu_pkg.sv | 40 ++++
 rtl/mdu_multicycle_if.sv | 35 +++
 rtl/mdu_arith.sv | 88 ++++++++
 rtl/mdu_multicycle.sv | 148 ++++++++++++++
 tb/tb_mdu_multicycle.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the multi-cycle multiply/divide unit:
//                MDUOP operation codes, ReadHILO select codes, FSM state
//                encoding and a helper for sizing the latency counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Operation codes carried on MDUOP
    localparam logic [3:0] MDUOP_NOP   = 4'd0;
    localparam logic [3:0] MDUOP_MULT  = 4'd1;
    localparam logic [3:0] MDUOP_MULTU = 4'd2;
    localparam logic [3:0] MDUOP_DIV   = 4'd3;
    localparam logic [3:0] MDUOP_DIVU  = 4'd4;
    localparam logic [3:0] MDUOP_MTHI  = 4'd5;
    localparam logic [3:0] MDUOP_MTLO  = 4'd6;

    // ReadHILO select codes; code 3 is reserved and reads as zero
    localparam logic [1:0] RD_NONE = 2'd0;
    localparam logic [1:0] RD_HI   = 2'd1;
    localparam logic [1:0] RD_LO   = 2'd2;

    // Control FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Counter width: $clog2 of the longer latency, never narrower than 1 bit
    // so that a single-cycle configuration still has a legal vector.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_multicycle_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_multicycle_if
//  Description : Decode/E-stage bundle for the multiply/divide unit.
//                master : decode side, drives Start/MDUOP/A/B/ReadHILO
//                slave  : MDU side, drives Busy/HI/LO/MDOut
//  Ports       : Start, MDUOP[3:0], A, B, ReadHILO[1:0] (master -> slave)
//                Busy, HI, LO, MDOut                  (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_multicycle_if #(
    parameter int DATA_W = 32
);
    logic              Start;
    logic [3:0]        MDUOP;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [1:0]        ReadHILO;
    logic              Busy;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;
    logic [DATA_W-1:0] MDOut;

    modport master (
        output Start, MDUOP, A, B, ReadHILO,
        input  Busy, HI, LO, MDOut
    );

    modport slave (
        input  Start, MDUOP, A, B, ReadHILO,
        output Busy, HI, LO, MDOut
    );

endinterface : mdu_multicycle_if
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Combinational datapath for the MDU. Produces the HI/LO pair
//                an operation would commit, plus a write enable that is low
//                for divide-by-zero and for non-arithmetic opcodes.
//  Ports       : i_op[3:0]  operation code
//                i_a, i_b   operands (dividend / divisor for DIV*)
//                o_hi, o_lo value to commit (remainder / quotient for DIV*)
//                o_we       1 when HI/LO should take o_hi/o_lo
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic [3:0]        i_op,
    input  wire logic [DATA_W-1:0] i_a,
    input  wire logic [DATA_W-1:0] i_b,
    output logic      [DATA_W-1:0] o_hi,
    output logic      [DATA_W-1:0] o_lo,
    output logic                   o_we
);

    logic                  w_mul_signed;
    logic                  w_div_signed;
    logic [2*DATA_W-1:0]   w_ext_a;
    logic [2*DATA_W-1:0]   w_ext_b;
    logic [2*DATA_W-1:0]   w_prod;
    logic                  w_neg_a;
    logic                  w_neg_b;
    logic [DATA_W-1:0]     w_mag_a;
    logic [DATA_W-1:0]     w_mag_b;
    logic [DATA_W-1:0]     w_divisor;
    logic [DATA_W-1:0]     w_mag_q;
    logic [DATA_W-1:0]     w_mag_r;
    logic [DATA_W-1:0]     w_quot;
    logic [DATA_W-1:0]     w_rem;
    logic                  w_div_zero;

    assign w_mul_signed = (i_op == MDUOP_MULT);
    assign w_div_signed = (i_op == MDUOP_DIV);

    // The low 2*DATA_W bits of a product of extended operands are the same
    // for signed and unsigned arithmetic, so one multiplier serves both.
    assign w_ext_a = w_mul_signed ? {{DATA_W{i_a[DATA_W-1]}}, i_a} : {{DATA_W{1'b0}}, i_a};
    assign w_ext_b = w_mul_signed ? {{DATA_W{i_b[DATA_W-1]}}, i_b} : {{DATA_W{1'b0}}, i_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed division is done on magnitudes. |INT_MIN| fits as an unsigned
    // DATA_W value, and negating the resulting quotient wraps back to INT_MIN,
    // which gives the INT_MIN / -1 -> INT_MIN, rem 0 result without a trap.
    assign w_neg_a    = w_div_signed & i_a[DATA_W-1];
    assign w_neg_b    = w_div_signed & i_b[DATA_W-1];
    assign w_mag_a    = w_neg_a ? (-i_a) : i_a;
    assign w_mag_b    = w_neg_b ? (-i_b) : i_b;
    assign w_div_zero = (i_b == '0);
    // Substitute a harmless divisor on /0; the result is discarded via o_we.
    assign w_divisor  = w_div_zero ? DATA_W'(1) : w_mag_b;
    assign w_mag_q    = w_mag_a / w_divisor;
    assign w_mag_r    = w_mag_a % w_divisor;
    assign w_quot     = (w_neg_a ^ w_neg_b) ? (-w_mag_q) : w_mag_q;
    assign w_rem      = w_neg_a ? (-w_mag_r) : w_mag_r;

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        o_we = 1'b0;
        case (i_op)
            MDUOP_MULT, MDUOP_MULTU: begin
                o_hi = w_prod[2*DATA_W-1:DATA_W];
                o_lo = w_prod[DATA_W-1:0];
                o_we = 1'b1;
            end
            MDUOP_DIV, MDUOP_DIVU: begin
                o_hi = w_rem;
                o_lo = w_quot;
                o_we = ~w_div_zero;
            end
            default: begin
                o_we = 1'b0;
            end
        endcase
    end

endmodule : mdu_arith
`default_nettype wire

// File: rtl/mdu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_multicycle
//  Description : Multi-cycle multiply/divide unit with architectural HI/LO.
//                The result is computed at launch and parked in pending
//                registers; HI/LO only change after the configured latency,
//                so reads during Busy see the pre-operation values.
//  Ports       : clk    system clock, rising edge
//                reset  asynchronous active-high, clears all state
//                bus    mdu_multicycle_if.slave (Start, MDUOP, A, B,
//                       ReadHILO in; Busy, HI, LO, MDOut out)
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic             clk,
    input  wire logic             reset,
    mdu_multicycle_if.slave       bus
);

    localparam int               CNT_W     = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    generate
        if (MULT_CYCLES < 1) begin : g_bad_mult_cycles
            $error("mdu_multicycle: MULT_CYCLES must be >= 1");
        end
        if (DIV_CYCLES < 1) begin : g_bad_div_cycles
            $error("mdu_multicycle: DIV_CYCLES must be >= 1");
        end
    endgenerate

    mdu_state_e        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DATA_W-1:0] hi_q,      hi_d;
    logic [DATA_W-1:0] lo_q,      lo_d;
    logic [DATA_W-1:0] pend_hi_q, pend_hi_d;
    logic [DATA_W-1:0] pend_lo_q, pend_lo_d;
    logic              pend_we_q, pend_we_d;

    logic [DATA_W-1:0] w_res_hi;
    logic [DATA_W-1:0] w_res_lo;
    logic              w_res_we;

    mdu_arith #(
        .DATA_W (DATA_W)
    ) u_arith (
        .i_op   (bus.MDUOP),
        .i_a    (bus.A),
        .i_b    (bus.B),
        .o_hi   (w_res_hi),
        .o_lo   (w_res_lo),
        .o_we   (w_res_we)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    case (bus.MDUOP)
                        MDUOP_MULT, MDUOP_MULTU: begin
                            pend_hi_d = w_res_hi;
                            pend_lo_d = w_res_lo;
                            pend_we_d = w_res_we;
                            cnt_d     = MULT_LOAD;
                            state_d   = ST_BUSY;
                        end
                        MDUOP_DIV, MDUOP_DIVU: begin
                            pend_hi_d = w_res_hi;
                            pend_lo_d = w_res_lo;
                            pend_we_d = w_res_we;
                            cnt_d     = DIV_LOAD;
                            state_d   = ST_BUSY;
                        end
                        MDUOP_MTHI: hi_d = bus.A;
                        MDUOP_MTLO: lo_d = bus.A;
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                // Start is deliberately ignored here; the hazard unit stalls.
                if (cnt_q == '0) begin
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.Busy = (state_q == ST_BUSY);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    always_comb begin
        case (bus.ReadHILO)
            RD_HI:   bus.MDOut = hi_q;
            RD_LO:   bus.MDOut = lo_q;
            default: bus.MDOut = '0;
        endcase
    end

endmodule : mdu_multicycle
`default_nettype wire

// File: tb/tb_mdu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_multicycle
//  Description : Self-checking bench for mdu_multicycle. A behavioural model
//                (plain 64-bit arithmetic plus a remaining-cycles count) is
//                compared against the DUT every falling edge; directed
//                vectors add literal expectations. A second instance with a
//                single-cycle multiply latency is checked directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_multicycle;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    mdu_multicycle_if #(.DATA_W(32)) bus  ();
    mdu_multicycle_if #(.DATA_W(32)) bus2 ();

    mdu_multicycle #(.DATA_W(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    mdu_multicycle #(.DATA_W(32), .MULT_CYCLES(1), .DIV_CYCLES(DC)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwe;
    int          m_rem;
    int          m_hazards;

    function automatic logic [64:0] model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MDUOP_MULT:  begin sp = sa * sb; return {1'b1, sp[63:0]}; end
            MDUOP_MULTU: begin up = ua * ub; return {1'b1, up[63:0]}; end
            MDUOP_DIV: begin
                if (b == 32'd0) return 65'd0;
                sq = sa / sb;
                sr = sa % sb;
                return {1'b1, sr[31:0], sq[31:0]};
            end
            MDUOP_DIVU: begin
                if (b == 32'd0) return 65'd0;
                uq = ua / ub;
                ur = ua % ub;
                return {1'b1, ur[31:0], uq[31:0]};
            end
            default: return 65'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [64:0] r;
        if (reset) begin
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
            m_phi <= 32'd0;
            m_plo <= 32'd0;
            m_pwe <= 1'b0;
            m_rem <= 0;
        end else if (m_rem > 0) begin
            if (bus.Start) m_hazards <= m_hazards + 1;
            if (m_rem == 1 && m_pwe) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
            m_rem <= m_rem - 1;
        end else if (bus.Start) begin
            case (bus.MDUOP)
                MDUOP_MULT, MDUOP_MULTU, MDUOP_DIV, MDUOP_DIVU: begin
                    r = model_op(bus.MDUOP, bus.A, bus.B);
                    m_pwe <= r[64];
                    m_phi <= r[63:32];
                    m_plo <= r[31:0];
                    m_rem <= (bus.MDUOP == MDUOP_MULT || bus.MDUOP == MDUOP_MULTU) ? MC : DC;
                end
                MDUOP_MTHI: m_hi <= bus.A;
                MDUOP_MTLO: m_lo <= bus.A;
                default: ;
            endcase
        end
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        logic [31:0] exp_md;
        case (bus.ReadHILO)
            RD_HI:   exp_md = m_hi;
            RD_LO:   exp_md = m_lo;
            default: exp_md = 32'd0;
        endcase
        chk("cyc_busy",  {31'b0, bus.Busy}, {31'b0, (m_rem > 0)});
        chk("cyc_hi",    bus.HI, m_hi);
        chk("cyc_lo",    bus.LO, m_lo);
        chk("cyc_mdout", bus.MDOut, exp_md);
    end

    // ---------------- stimulus helpers ----------------
    task automatic op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.MDUOP = o;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.MDUOP = MDUOP_NOP;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.Busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        tests_run    = 0;
        tests_failed = 0;
        m_hazards    = 0;
        reset        = 1'b1;
        bus.Start    = 1'b0;
        bus.MDUOP    = MDUOP_NOP;
        bus.A        = 32'd0;
        bus.B        = 32'd0;
        bus.ReadHILO = RD_NONE;
        bus2.Start    = 1'b0;
        bus2.MDUOP    = MDUOP_NOP;
        bus2.A        = 32'd0;
        bus2.B        = 32'd0;
        bus2.ReadHILO = RD_NONE;
        repeat (2) @(negedge clk);
        chk("rst_busy",  {31'b0, bus.Busy}, 32'd0);
        chk("rst_hi",    bus.HI, 32'd0);
        chk("rst_lo",    bus.LO, 32'd0);
        chk("rst_mdout", bus.MDOut, 32'd0);
        reset = 1'b0;

        // MULT -3 * 7
        op(MDUOP_MULT, 32'hFFFF_FFFD, 32'd7);
        count_busy(n);
        chk("mult_len", 32'(n), 32'd5);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFEB);

        // DIVU 100 / 7, DIV -7 / 2
        op(MDUOP_DIVU, 32'd100, 32'd7);
        count_busy(n);
        chk("divu_len", 32'(n), 32'd10);
        chk("divu_lo", bus.LO, 32'd14);
        chk("divu_hi", bus.HI, 32'd2);
        op(MDUOP_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);

        // Preload, divide by zero, INT_MIN / -1
        op(MDUOP_MTLO, 32'h55, 32'd0);
        chk("mtlo_busy", {31'b0, bus.Busy}, 32'd0);
        chk("mtlo_lo", bus.LO, 32'h55);
        op(MDUOP_MTHI, 32'h66, 32'd0);
        chk("mthi_hi", bus.HI, 32'h66);
        op(MDUOP_DIV, 32'd1234, 32'd0);
        count_busy(n);
        chk("dz_len", 32'(n), 32'd10);
        chk("dz_hi", bus.HI, 32'h66);
        chk("dz_lo", bus.LO, 32'h55);
        op(MDUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        chk("ovf_lo", bus.LO, 32'h8000_0000);
        chk("ovf_hi", bus.HI, 32'd0);

        // NOP / reserved opcode has no effect
        op(MDUOP_NOP, 32'h1234, 32'h5678);
        op(4'hF, 32'h1234, 32'h5678);
        chk("nop_busy", {31'b0, bus.Busy}, 32'd0);
        chk("nop_hi", bus.HI, 32'd0);

        // MULTU with a second Start while busy
        op(MDUOP_MULTU, 32'hFFFF_FFFF, 32'd2);
        bus.Start = 1'b1;
        bus.MDUOP = MDUOP_MULT;
        bus.A     = 32'd3;
        bus.B     = 32'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.MDUOP = MDUOP_NOP;
        count_busy(n);
        chk("hz_len", 32'(n), 32'd4);
        chk("hz_hi", bus.HI, 32'd1);
        chk("hz_lo", bus.LO, 32'hFFFF_FFFE);
        repeat (12) @(negedge clk);
        chk("hz_hi_hold", bus.HI, 32'd1);
        chk("hz_lo_hold", bus.LO, 32'hFFFF_FFFE);
        chk("hz_busy_hold", {31'b0, bus.Busy}, 32'd0);
        chk("hz_count", 32'(m_hazards), 32'd1);

        // Reads during Busy return pre-op values
        op(MDUOP_MTHI, 32'hAAAA, 32'd0);
        op(MDUOP_MTLO, 32'hBBBB, 32'd0);
        op(MDUOP_MULT, 32'd2, 32'd3);
        #2 bus.ReadHILO = RD_HI;
        #1 chk("rd_hi_busy", bus.MDOut, 32'hAAAA);
        @(negedge clk);
        #2 bus.ReadHILO = RD_LO;
        #1 chk("rd_lo_busy", bus.MDOut, 32'hBBBB);
        @(negedge clk);
        #2 bus.ReadHILO = 2'd3;
        #1 chk("rd_rsv", bus.MDOut, 32'd0);
        @(negedge clk);
        #2 bus.ReadHILO = RD_LO;
        count_busy(n);
        chk("rd_after_lo", bus.MDOut, 32'd6);
        chk("rd_after_hi", bus.HI, 32'd0);
        #2 bus.ReadHILO = RD_NONE;

        // Reset two cycles into a DIV
        op(MDUOP_MTHI, 32'h11, 32'd0);
        op(MDUOP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'b0, bus.Busy}, 32'd0);
        chk("rst_mid_hi", bus.HI, 32'd0);
        chk("rst_mid_lo", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_late_hi", bus.HI, 32'd0);
        chk("rst_late_lo", bus.LO, 32'd0);

        // Single-cycle multiply configuration
        @(negedge clk);
        bus2.Start = 1'b1;
        bus2.MDUOP = MDUOP_MULT;
        bus2.A     = 32'd5;
        bus2.B     = 32'hFFFF_FFFF;
        @(negedge clk);
        bus2.Start = 1'b0;
        bus2.MDUOP = MDUOP_NOP;
        n = 0;
        while (bus2.Busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("m1_len", 32'(n), 32'd1);
        chk("m1_hi", bus2.HI, 32'hFFFF_FFFF);
        chk("m1_lo", bus2.LO, 32'hFFFF_FFFB);

        // Pin the model itself against hand values
        begin
            logic [64:0] r;
            r = model_op(MDUOP_DIV, 32'hFFFF_FFF9, 32'd2);
            chk("model_div_q", r[31:0], 32'hFFFF_FFFD);
            chk("model_div_r", r[63:32], 32'hFFFF_FFFF);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_mdu_multicycle
`default_nettype wire
